// File: rtl/multi_mole_detector.sv
// multi_mole_detector
//
// Purpose:
//   Tracks N_MOLES independent mole channels. Each channel arms when its mole
//   lights up. It then reports a hit when its button is pressed, or a miss when
//   the window ends. A window ends on a led_toggle pulse, when the mole goes
//   dark, or when the optional cycle timeout expires. Three saturating score
//   counters total the hits, misses and wrong presses. The block sits between
//   the LED/mole generator plus the button debouncers and the scoring/display
//   logic.
//
// Parameters:
//   N_MOLES      number of mole/LED/button channels
//   TIMEOUT_CYC  per-channel window in clock cycles, 0 = no cycle timeout
//   CNT_W        width of each saturating score counter
//
// Configuration macro:
//   MULTI_MOLE_WRONG_PRESS_EN  when defined, presses on unarmed channels are
//                              reported on wrong_vec_o and counted in
//                              wrong_count_o. When undefined, both outputs are
//                              tied to 0 and those presses are ignored.
//
// Ports:
//   clk_i            system clock, all logic on the rising edge
//   rst_ni           asynchronous active-low reset
//   led_toggle_i     1-cycle timer pulse that ends every armed window
//   active_onehot_i  level, bit i high while mole i is lit
//   btn_edge_i       debounced rising-edge pulses, one per button
//   clr_counts_i     synchronous clear of all score counters
//   armed_o          level, channel i is waiting for a hit
//   hit_vec_o        1-cycle pulse per channel on a correct hit
//   miss_vec_o       1-cycle pulse per channel on window expiry
//   wrong_vec_o      1-cycle pulse per channel on a press while not armed
//   hit_pulse_o      OR of hit_vec_o
//   miss_pulse_o     OR of miss_vec_o
//   hit_count_o      saturating hit total
//   miss_count_o     saturating miss total
//   wrong_count_o    saturating wrong-press total
module multi_mole_detector #(
    parameter int N_MOLES     = 10,
    parameter int TIMEOUT_CYC = 0,
    parameter int CNT_W       = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               led_toggle_i,
    input  logic [N_MOLES-1:0] active_onehot_i,
    input  logic [N_MOLES-1:0] btn_edge_i,
    input  logic               clr_counts_i,
    output logic [N_MOLES-1:0] armed_o,
    output logic [N_MOLES-1:0] hit_vec_o,
    output logic [N_MOLES-1:0] miss_vec_o,
    output logic [N_MOLES-1:0] wrong_vec_o,
    output logic               hit_pulse_o,
    output logic               miss_pulse_o,
    output logic [CNT_W-1:0]   hit_count_o,
    output logic [CNT_W-1:0]   miss_count_o,
    output logic [CNT_W-1:0]   wrong_count_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2,
        COOL  = 2'd3
    } chanState_e;

    localparam int AGE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int SUM_W = CNT_W + $clog2(N_MOLES + 1);
    localparam logic [AGE_W-1:0] AGE_LAST =
        AGE_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam bit TIMEOUT_EN = (TIMEOUT_CYC != 0);

    chanState_e         state_q [N_MOLES];
    chanState_e         state_d [N_MOLES];
    logic [AGE_W-1:0]   age_q   [N_MOLES];
    logic [AGE_W-1:0]   age_d   [N_MOLES];
    logic [N_MOLES-1:0] hit_d, hit_q;
    logic [N_MOLES-1:0] miss_d, miss_q;
    logic [CNT_W-1:0]   hit_count_d, hit_count_q;
    logic [CNT_W-1:0]   miss_count_d, miss_count_q;

    // The sum is computed at a wider width so that adding a full vector of
    // pulses can be detected as overflow and clamped, never wrapped.
    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0]   cur,
                                                 input logic [N_MOLES-1:0] pulses);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cur);
        for (int k = 0; k < N_MOLES; k++) begin
            sum = sum + SUM_W'(pulses[k]);
        end
        if (sum > SUM_W'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return sum[CNT_W-1:0];
    endfunction

    // Per-channel next state. The button test comes first, so a press in the
    // same cycle as led_toggle counts as a hit. DONE lasts exactly one cycle.
    // COOL holds the channel off until its mole goes dark, so the same lit
    // period cannot arm the channel a second time.
    always_comb begin
        hit_d  = '0;
        miss_d = '0;
        for (int i = 0; i < N_MOLES; i++) begin
            state_d[i] = state_q[i];
            age_d[i]   = age_q[i];
            case (state_q[i])
                IDLE: begin
                    if (active_onehot_i[i]) begin
                        state_d[i] = ARMED;
                        age_d[i]   = '0;
                    end
                end
                ARMED: begin
                    if (btn_edge_i[i]) begin
                        state_d[i] = DONE;
                        hit_d[i]   = 1'b1;
                    end else if (led_toggle_i || !active_onehot_i[i] ||
                                 (TIMEOUT_EN && (age_q[i] == AGE_LAST))) begin
                        state_d[i] = DONE;
                        miss_d[i]  = 1'b1;
                    end else begin
                        age_d[i] = age_q[i] + AGE_W'(1);
                    end
                end
                DONE: begin
                    state_d[i] = active_onehot_i[i] ? COOL : IDLE;
                end
                COOL: begin
                    if (!active_onehot_i[i]) begin
                        state_d[i] = IDLE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase
        end
    end

    // A reset in the middle of a window simply drops it, with no miss pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_MOLES; i++) begin
                state_q[i] <= IDLE;
                age_q[i]   <= '0;
            end
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            for (int i = 0; i < N_MOLES; i++) begin
                state_q[i] <= state_d[i];
                age_q[i]   <= age_d[i];
            end
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    always_comb begin
        armed_o = '0;
        for (int i = 0; i < N_MOLES; i++) begin
            armed_o[i] = (state_q[i] == ARMED);
        end
    end

    // The counters absorb the registered pulses while those pulses are visible.
    // A clear wins over an increment in the same cycle.
    always_comb begin
        hit_count_d  = clr_counts_i ? '0 : satAdd(hit_count_q, hit_q);
        miss_count_d = clr_counts_i ? '0 : satAdd(miss_count_q, miss_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_vec_o    = hit_q;
    assign miss_vec_o   = miss_q;
    assign hit_pulse_o  = |hit_q;
    assign miss_pulse_o = |miss_q;
    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;

`ifdef MULTI_MOLE_WRONG_PRESS_EN
    logic [N_MOLES-1:0] wrong_d, wrong_q;
    logic [CNT_W-1:0]   wrong_count_d, wrong_count_q;

    // Any press on a channel that is not armed counts as a wrong press. This
    // includes presses while the channel is in DONE or COOL.
    always_comb begin
        wrong_d = '0;
        for (int i = 0; i < N_MOLES; i++) begin
            wrong_d[i] = btn_edge_i[i] && (state_q[i] != ARMED);
        end
        wrong_count_d = clr_counts_i ? '0 : satAdd(wrong_count_q, wrong_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrong_q       <= '0;
            wrong_count_q <= '0;
        end else begin
            wrong_q       <= wrong_d;
            wrong_count_q <= wrong_count_d;
        end
    end

    assign wrong_vec_o   = wrong_q;
    assign wrong_count_o = wrong_count_q;
`else
    assign wrong_vec_o   = '0;
    assign wrong_count_o = '0;
`endif

endmodule
